// File: rtl/ifu_fetch_bridge_if.sv
// Fetch bridge bus: PC-control handshake, redirect and instruction memory port.
// master drives requests/responses into the bridge; slave is the bridge view.
interface ifu_fetch_bridge_if #(
  parameter int PC_WIDTH    = 64,
  parameter int FETCH_WIDTH = 128
);
  logic                   pc_index_valid;
  logic [PC_WIDTH-1:0]    pc_index;
  logic                   pc_index_ready;
  logic                   pc_operation_done;
  logic [FETCH_WIDTH-1:0] pc_read_inst;
  logic                   fetch_fault;
  logic                   redirect_valid;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [PC_WIDTH-1:0]    mem_req_addr;
  logic                   mem_resp_valid;
  logic [FETCH_WIDTH-1:0] mem_resp_data;
  logic                   mem_resp_err;

  modport master (
    output pc_index_valid, pc_index, redirect_valid,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_data, mem_resp_err,
    input  pc_index_ready, pc_operation_done,
    input  pc_read_inst, fetch_fault,
    input  mem_req_valid, mem_req_addr
  );

  modport slave (
    input  pc_index_valid, pc_index, redirect_valid,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_data, mem_resp_err,
    output pc_index_ready, pc_operation_done,
    output pc_read_inst, fetch_fault,
    output mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ifu_fetch_bridge.sv
// Single-outstanding PC-to-imem fetch bridge with redirect flush.
// Optional IFU_FETCH_PERF_EN adds saturating fetch/drop counters.
module ifu_fetch_bridge #(
  parameter int PC_WIDTH    = 64,
  parameter int FETCH_WIDTH = 128
) (
  input  logic clock,
  input  logic reset,
  ifu_fetch_bridge_if.slave bus
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [FETCH_WIDTH-1:0] inst_q, inst_d;
  logic                   drop_q, drop_d;
  logic                   done_q, done_d;
  logic                   fault_q, fault_d;
  logic                   discard;

  assign bus.pc_index_ready    = (state_q == IDLE) && !bus.redirect_valid;
  assign bus.mem_req_valid     = (state_q == REQ);
  assign bus.mem_req_addr      = addr_q;
  assign bus.pc_read_inst      = inst_q;
  assign bus.pc_operation_done = done_q;
  assign bus.fetch_fault       = fault_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    discard = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (bus.pc_index_valid && bus.pc_index_ready) begin
          addr_d  = bus.pc_index & ~PC_WIDTH'(15);
          state_d = REQ;
        end
      end
      REQ: begin
        // request stays up through a redirect; the flush lands on the response
        if (bus.redirect_valid) drop_d = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = (drop_q || bus.redirect_valid) ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = IDLE;
          if (bus.redirect_valid) begin
            discard = 1'b1;
          end else begin
            done_d  = 1'b1;
            fault_d = bus.mem_resp_err;
            inst_d  = bus.mem_resp_err ? '0 : bus.mem_resp_data;
          end
        end else if (bus.redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          discard = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inst_q  <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (done_d && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (discard && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule
